// File: rtl/cam_pkg.sv
// Shared definitions for the CAM command path: opcodes, widths and the
// header beat layout. Used by the dispatcher and by the CAM itself.
package cam_pkg;

  localparam int C_DATA_WIDTH  = 512;
  localparam int OP_CODE_WIDTH = 3;

  // Header beat layout: opcode in the low bits, beat count in bits 63:32.
  localparam int HDR_OP_LSB    = 0;
  localparam int HDR_CNT_LSB   = 32;
  localparam int HDR_CNT_WIDTH = 32;

  // Opcodes carried in a header; the same encoding is reported on cam_state.
  typedef enum logic [OP_CODE_WIDTH-1:0] {
    OP_IDLE       = 3'd0,
    OP_UPDATE_ALL = 3'd1,
    OP_SEARCH     = 3'd2,
    OP_UPDATE_ONE = 3'd3,
    OP_TOPOLOGY   = 3'd4
  } cam_op_e;

  // Dispatcher control states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_ALL = 2'd1,
    ST_STREAM   = 2'd2,
    ST_DRAIN    = 2'd3
  } disp_state_e;

endpackage

// File: rtl/cam_cmd_dispatcher_if.sv
// Bundle of the host-stream and CAM-side signals of the command dispatcher.
// The dispatcher uses the slave view; the host/CAM environment the master view.
interface cam_cmd_dispatcher_if #(
  parameter int C_DATA_WIDTH  = cam_pkg::C_DATA_WIDTH,
  parameter int OP_CODE_WIDTH = cam_pkg::OP_CODE_WIDTH
);
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [C_DATA_WIDTH-1:0]  s_axis_tdata;
  logic [OP_CODE_WIDTH-1:0] cam_state;
  logic [31:0]              cam_update_num;
  logic                     cam_tvalid;
  logic [C_DATA_WIDTH-1:0]  cam_tdata;
  logic                     cam_update_all_end;
  logic                     busy;
  logic                     err_opcode;
  logic                     err_sync;

  modport master (
    output s_axis_tvalid, s_axis_tdata, cam_update_all_end,
    input  s_axis_tready, cam_state, cam_update_num, cam_tvalid, cam_tdata,
           busy, err_opcode, err_sync
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, cam_update_all_end,
    output s_axis_tready, cam_state, cam_update_num, cam_tvalid, cam_tdata,
           busy, err_opcode, err_sync
  );
endinterface

// File: rtl/cam_cmd_dispatcher.sv
// Command dispatcher between a host beat stream and the CAM. Decodes header
// beats, forwards payload beats with one cycle of latency, tracks the
// remaining beat count and checks the CAM end-of-load pulse on full loads.
module cam_cmd_dispatcher #(
  parameter int C_DATA_WIDTH     = cam_pkg::C_DATA_WIDTH,
  parameter int CAM_SIZE         = 256,
  parameter int ENTRIES_PER_BEAT = 16,
  parameter int OP_CODE_WIDTH    = cam_pkg::OP_CODE_WIDTH
) (
  input logic                 aclk,
  input logic                 areset,
  cam_cmd_dispatcher_if.slave bus
);

  // Number of payload beats in a full-table load.
  localparam logic [31:0] LOAD_BEATS = 32'(CAM_SIZE / ENTRIES_PER_BEAT);

  localparam logic [OP_CODE_WIDTH-1:0] OPC_IDLE       = OP_CODE_WIDTH'(cam_pkg::OP_IDLE);
  localparam logic [OP_CODE_WIDTH-1:0] OPC_UPDATE_ALL = OP_CODE_WIDTH'(cam_pkg::OP_UPDATE_ALL);
  localparam logic [OP_CODE_WIDTH-1:0] OPC_SEARCH     = OP_CODE_WIDTH'(cam_pkg::OP_SEARCH);
  localparam logic [OP_CODE_WIDTH-1:0] OPC_UPDATE_ONE = OP_CODE_WIDTH'(cam_pkg::OP_UPDATE_ONE);
  localparam logic [OP_CODE_WIDTH-1:0] OPC_TOPOLOGY   = OP_CODE_WIDTH'(cam_pkg::OP_TOPOLOGY);

  cam_pkg::disp_state_e     r_state, w_state_next;
  logic [OP_CODE_WIDTH-1:0] r_cam_state, w_cam_state_next;
  logic                     r_cam_tvalid, w_cam_tvalid_next;
  logic [C_DATA_WIDTH-1:0]  r_cam_tdata, w_cam_tdata_next;
  logic [31:0]              r_update_num, w_update_num_next;
  logic [31:0]              r_remaining, w_remaining_next;
  logic                     r_last_load, w_last_load_next;
  logic                     r_err_opcode, w_err_opcode_next;
  logic                     r_err_sync, w_err_sync_next;
  logic                     r_out_en;

  logic                     w_tready;
  logic                     w_accept;
  logic [OP_CODE_WIDTH-1:0] w_hdr_op;
  logic [31:0]              w_hdr_cnt;
  logic                     w_end_expected;

  // Ready is held low while in reset and until the first edge after release,
  // and dropped for the single drain cycle that closes each command.
  assign w_tready  = r_out_en && (r_state != cam_pkg::ST_DRAIN);
  assign w_accept  = bus.s_axis_tvalid && w_tready;
  assign w_hdr_op  = bus.s_axis_tdata[cam_pkg::HDR_OP_LSB +: OP_CODE_WIDTH];
  assign w_hdr_cnt = bus.s_axis_tdata[cam_pkg::HDR_CNT_LSB +: cam_pkg::HDR_CNT_WIDTH];

  // The CAM must pulse end-of-load exactly while the final load beat is on
  // cam_tvalid, which falls in the drain cycle because of output registering.
  assign w_end_expected = r_cam_tvalid && r_last_load;

  // Next-state, datapath and error-flag logic for the command FSM.
  always_comb begin
    w_state_next      = r_state;
    w_cam_state_next  = r_cam_state;
    w_cam_tvalid_next = 1'b0;
    w_cam_tdata_next  = r_cam_tdata;
    w_update_num_next = r_update_num;
    w_remaining_next  = r_remaining;
    w_last_load_next  = 1'b0;
    w_err_opcode_next = r_err_opcode;
    w_err_sync_next   = r_err_sync;

    case (r_state)
      cam_pkg::ST_IDLE: begin
        w_cam_state_next = OPC_IDLE;
        if (w_accept) begin
          if (w_hdr_op == OPC_TOPOLOGY) begin
            // Topology beats pass straight through without leaving idle.
            w_cam_tvalid_next = 1'b1;
            w_cam_tdata_next  = bus.s_axis_tdata;
          end else if (w_hdr_op == OPC_UPDATE_ALL) begin
            // Full load ignores the header count; the table size fixes it.
            w_state_next      = cam_pkg::ST_LOAD_ALL;
            w_cam_state_next  = OPC_UPDATE_ALL;
            w_update_num_next = LOAD_BEATS;
            w_remaining_next  = LOAD_BEATS;
          end else if (w_hdr_op == OPC_SEARCH || w_hdr_op == OPC_UPDATE_ONE) begin
            w_cam_state_next  = w_hdr_op;
            w_update_num_next = w_hdr_cnt;
            w_remaining_next  = w_hdr_cnt;
            w_state_next      = (w_hdr_cnt == 32'd0) ? cam_pkg::ST_DRAIN
                                                     : cam_pkg::ST_STREAM;
          end else begin
            // Unknown opcode: drop the beat and remember it.
            w_err_opcode_next = 1'b1;
          end
        end
      end

      cam_pkg::ST_LOAD_ALL, cam_pkg::ST_STREAM: begin
        if (w_accept) begin
          w_cam_tvalid_next = 1'b1;
          w_cam_tdata_next  = bus.s_axis_tdata;
          w_remaining_next  = r_remaining - 32'd1;
          if (r_remaining == 32'd1) begin
            w_state_next     = cam_pkg::ST_DRAIN;
            w_last_load_next = (r_state == cam_pkg::ST_LOAD_ALL);
          end
        end
      end

      cam_pkg::ST_DRAIN: begin
        w_state_next     = cam_pkg::ST_IDLE;
        w_cam_state_next = OPC_IDLE;
        w_remaining_next = 32'd0;
      end

      default: begin
        w_state_next     = cam_pkg::ST_IDLE;
        w_cam_state_next = OPC_IDLE;
      end
    endcase

    // End-of-load sync is judged for the whole full-load command, including
    // its drain cycle; a pulse on the wrong beat or a missing pulse both flag.
    if (r_cam_state == OPC_UPDATE_ALL && (bus.cam_update_all_end != w_end_expected)) begin
      w_err_sync_next = 1'b1;
    end
  end

  // State and output registers, cleared immediately by the async reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= cam_pkg::ST_IDLE;
      r_cam_state  <= '0;
      r_cam_tvalid <= 1'b0;
      r_cam_tdata  <= '0;
      r_update_num <= '0;
      r_remaining  <= '0;
      r_last_load  <= 1'b0;
      r_err_opcode <= 1'b0;
      r_err_sync   <= 1'b0;
      r_out_en     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cam_state  <= w_cam_state_next;
      r_cam_tvalid <= w_cam_tvalid_next;
      r_cam_tdata  <= w_cam_tdata_next;
      r_update_num <= w_update_num_next;
      r_remaining  <= w_remaining_next;
      r_last_load  <= w_last_load_next;
      r_err_opcode <= w_err_opcode_next;
      r_err_sync   <= w_err_sync_next;
      r_out_en     <= 1'b1;
    end
  end

  assign bus.s_axis_tready  = w_tready;
  assign bus.cam_state      = r_cam_state;
  assign bus.cam_update_num = r_update_num;
  assign bus.cam_tvalid     = r_cam_tvalid;
  assign bus.cam_tdata      = r_cam_tdata;
  assign bus.busy           = (r_state != cam_pkg::ST_IDLE);
  assign bus.err_opcode     = r_err_opcode;
  assign bus.err_sync       = r_err_sync;

endmodule

// File: tb/tb_cam_cmd_dispatcher.sv
// Scoreboard bench for cam_cmd_dispatcher: forwarded beats are predicted when
// driven and compared when they appear on the CAM side.
module tb_cam_cmd_dispatcher;

  localparam int DW = 512;

  typedef struct packed {
    logic [2:0]    st;
    logic [DW-1:0] data;
  } exp_t;

  logic aclk;
  logic areset;

  cam_cmd_dispatcher_if #(.C_DATA_WIDTH(DW), .OP_CODE_WIDTH(3)) bus ();

  cam_cmd_dispatcher #(
    .C_DATA_WIDTH(DW), .CAM_SIZE(256), .ENTRIES_PER_BEAT(16), .OP_CODE_WIDTH(3)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus)
  );

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   fwd_cnt = 0;
  int   load_seen = 0;
  int   end_on_beat = 16;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] make_hdr(input logic [2:0] op, input logic [31:0] n);
    logic [DW-1:0] r;
    r = rand_data();
    r[2:0]   = op;
    r[63:32] = n;
    return r;
  endfunction

  // Drive one beat starting at a falling edge; returns at the falling edge
  // after the rising edge that accepted it.
  task automatic send_beat(input logic [DW-1:0] d);
    int waited;
    waited = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = 1'b1;
    while (!bus.s_axis_tready && waited < 50) begin
      @(negedge aclk);
      waited++;
    end
    if (!bus.s_axis_tready) check_val("ready_timeout", 512'(0), 512'(1));
    @(posedge aclk);
    @(negedge aclk);
    bus.s_axis_tvalid = 1'b0;
    $display("beat sent op=%0d low=%0h", d[2:0], d[63:0]);
  endtask

  task automatic send_fwd(input logic [2:0] st, input logic [DW-1:0] d);
    exp_t e;
    e.st   = st;
    e.data = d;
    exp_q.push_back(e);
    send_beat(d);
  endtask

  // Monitor: compares CAM-side beats against the scoreboard and plays the
  // CAM's end-of-load pulse on the chosen load beat.
  initial begin
    bus.cam_update_all_end = 1'b0;
    forever begin
      @(negedge aclk);
      if (bus.cam_state != 3'd1) load_seen = 0;
      if (bus.cam_tvalid) begin
        exp_t e;
        fwd_cnt++;
        if (bus.cam_state == 3'd1) load_seen++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", 512'(1), 512'(0));
        end else begin
          e = exp_q.pop_front();
          check_val("beat_data", bus.cam_tdata, e.data);
          check_val("beat_state", 512'(bus.cam_state), 512'(e.st));
        end
      end
      bus.cam_update_all_end = bus.cam_tvalid && (bus.cam_state == 3'd1) && (load_seen == end_on_beat);
    end
  end

  // Full-table load of 16 beats followed by drain/idle checks.
  task automatic run_update_all(input int end_beat, input logic want_sync);
    int c0;
    end_on_beat = end_beat;
    c0 = fwd_cnt;
    send_beat(make_hdr(3'd1, 32'd99));
    check_val("ua_hdr_busy", 512'(bus.busy), 512'(1));
    check_val("ua_hdr_state", 512'(bus.cam_state), 512'(1));
    check_val("ua_hdr_no_fwd", 512'(bus.cam_tvalid), 512'(0));
    for (int i = 0; i < 16; i++) send_fwd(3'd1, rand_data());
    check_val("ua_drain_busy", 512'(bus.busy), 512'(1));
    check_val("ua_drain_ready", 512'(bus.s_axis_tready), 512'(0));
    check_val("ua_drain_state", 512'(bus.cam_state), 512'(1));
    @(negedge aclk);
    check_val("ua_idle_busy", 512'(bus.busy), 512'(0));
    check_val("ua_idle_state", 512'(bus.cam_state), 512'(0));
    check_val("ua_idle_ready", 512'(bus.s_axis_tready), 512'(1));
    check_val("ua_fwd_count", 512'(fwd_cnt - c0), 512'(16));
    check_val("ua_err_sync", 512'(bus.err_sync), 512'(want_sync));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [DW-1:0] d;
    areset = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    @(negedge aclk);
    @(negedge aclk);
    check_val("rst_ready", 512'(bus.s_axis_tready), 512'(0));
    check_val("rst_busy", 512'(bus.busy), 512'(0));
    check_val("rst_tvalid", 512'(bus.cam_tvalid), 512'(0));
    check_val("rst_tdata", bus.cam_tdata, 512'(0));
    check_val("rst_state", 512'(bus.cam_state), 512'(0));
    check_val("rst_num", 512'(bus.cam_update_num), 512'(0));
    check_val("rst_errs", 512'({bus.err_opcode, bus.err_sync}), 512'(0));
    areset = 1'b0;
    @(negedge aclk);
    check_val("ready_after_rst", 512'(bus.s_axis_tready), 512'(1));

    // Full load with end pulse on beat 16.
    run_update_all(16, 1'b0);

    // SEARCH N=3 with a two-cycle gap after the first beat.
    c0 = fwd_cnt;
    send_beat(make_hdr(3'd2, 32'd3));
    check_val("srch_num", 512'(bus.cam_update_num), 512'(3));
    check_val("srch_state", 512'(bus.cam_state), 512'(2));
    check_val("srch_busy", 512'(bus.busy), 512'(1));
    send_fwd(3'd2, rand_data());
    @(negedge aclk);
    check_val("gap1_tvalid", 512'(bus.cam_tvalid), 512'(0));
    @(negedge aclk);
    check_val("gap2_tvalid", 512'(bus.cam_tvalid), 512'(0));
    send_fwd(3'd2, rand_data());
    send_fwd(3'd2, rand_data());
    check_val("srch_drain_ready", 512'(bus.s_axis_tready), 512'(0));
    @(negedge aclk);
    check_val("srch_idle_busy", 512'(bus.busy), 512'(0));
    check_val("srch_fwd_count", 512'(fwd_cnt - c0), 512'(3));

    // TOPOLOGY passes through in idle.
    d = rand_data();
    d[31:0] = 32'd4;
    send_fwd(3'd0, d);
    check_val("topo_tvalid", 512'(bus.cam_tvalid), 512'(1));
    check_val("topo_busy", 512'(bus.busy), 512'(0));
    @(negedge aclk);
    check_val("topo_busy_after", 512'(bus.busy), 512'(0));

    // Bad opcode, then an empty SEARCH.
    c0 = fwd_cnt;
    send_beat(make_hdr(3'd6, 32'd5));
    check_val("badop_err", 512'(bus.err_opcode), 512'(1));
    check_val("badop_busy", 512'(bus.busy), 512'(0));
    send_beat(make_hdr(3'd2, 32'd0));
    check_val("n0_drain_busy", 512'(bus.busy), 512'(1));
    check_val("n0_drain_ready", 512'(bus.s_axis_tready), 512'(0));
    @(negedge aclk);
    check_val("n0_idle_busy", 512'(bus.busy), 512'(0));
    check_val("n0_fwd_count", 512'(fwd_cnt - c0), 512'(0));
    check_val("err_opcode_sticky", 512'(bus.err_opcode), 512'(1));

    // Reset in the middle of a full load.
    end_on_beat = 16;
    send_beat(make_hdr(3'd1, 32'd0));
    for (int i = 0; i < 7; i++) send_fwd(3'd1, rand_data());
    #2;
    areset = 1'b1;
    #1;
    check_val("mid_rst_ready", 512'(bus.s_axis_tready), 512'(0));
    check_val("mid_rst_busy", 512'(bus.busy), 512'(0));
    check_val("mid_rst_tvalid", 512'(bus.cam_tvalid), 512'(0));
    check_val("mid_rst_tdata", bus.cam_tdata, 512'(0));
    check_val("mid_rst_state", 512'(bus.cam_state), 512'(0));
    check_val("mid_rst_num", 512'(bus.cam_update_num), 512'(0));
    check_val("mid_rst_errs", 512'({bus.err_opcode, bus.err_sync}), 512'(0));
    exp_q.delete();
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check_val("mid_rst_ready_back", 512'(bus.s_axis_tready), 512'(1));
    run_update_all(16, 1'b0);

    // End pulse one beat early.
    run_update_all(15, 1'b1);

    repeat (3) @(negedge aclk);
    check_val("queue_empty", 512'(exp_q.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_cmd_dispatcher.md
CAM_CMD_DISPATCHER -- requirements
Module: cam_cmd_dispatcher

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 512, beat width.
REQ-002 SHALL have parameter CAM_SIZE, default 256, number of CAM entries.
REQ-003 SHALL have parameter ENTRIES_PER_BEAT, default 16, CAM entries written per UPDATE_ALL beat.
REQ-004 SHALL have parameter OP_CODE_WIDTH, default 3, CAM state/opcode width.
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-high.
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- s_axis_tvalid  in  1  host beat valid.
- s_axis_tready  out  1  host beat ready.
- s_axis_tdata  in  C_DATA_WIDTH  host beat.
- cam_state  out  OP_CODE_WIDTH  CAM operating state.
- cam_update_num  out  32  latched beat count of the current command.
- cam_tvalid  out  1  beat valid to CAM.
- cam_tdata  out  C_DATA_WIDTH  beat to CAM.
- cam_update_all_end  in  1  CAM end-of-load pulse.
- busy  out  1  command in progress.
- err_opcode  out  1  sticky flag: bad opcode seen.
- err_sync  out  1  sticky flag: end-of-load mismatch.

Function
REQ-006 SHALL decode opcodes as follows: IDLE=0, UPDATE_ALL=1, SEARCH=2, UPDATE_ONE=3, TOPOLOGY=4.
REQ-007 SHALL use a header beat with opcode in tdata[2:0] and beat count N in tdata[63:32]; a header is accepted on tvalid&&tready in state IDLE.
REQ-008 SHALL implement FSM states IDLE, LOAD_ALL, STREAM and DRAIN.
REQ-009 SHALL register cam_state, cam_tvalid and cam_tdata, giving 1-cycle latency from the accepted input beat.
REQ-010 SHALL drive s_tready=1 in IDLE, LOAD_ALL and STREAM, and s_tready=0 in DRAIN; the CAM has no backpressure.
REQ-011 SHALL handle a TOPOLOGY header in IDLE as follows: forward the beat unchanged with cam_tvalid=1 and cam_state=IDLE for one cycle; remain in IDLE.
REQ-012 SHALL handle an UPDATE_ALL header by going to LOAD_ALL with cam_state=UPDATE_ALL; the header is not forwarded; the FSM expects exactly CAM_SIZE/ENTRIES_PER_BEAT (16) payload beats.
REQ-013 SHALL handle a SEARCH or UPDATE_ONE header by latching N into cam_update_num and going to STREAM with cam_state=opcode; the header is not forwarded.
REQ-014 SHALL, when N=0, go from the header directly to DRAIN with no beats forwarded.
REQ-015 SHALL forward each accepted payload beat with cam_tvalid=1 and decrement a 32-bit remaining counter per beat.
REQ-016 SHALL, after the last payload beat, go to DRAIN for exactly 1 cycle with cam_state held, then return to IDLE with cam_state=IDLE.
REQ-017 SHALL sample cam_update_all_end in LOAD_ALL, where it must coincide with the cycle cam_tvalid carries beat 16.
REQ-018 SHALL set err_sync if cam_update_all_end arrives on any other beat, or is missing at beat 16; the FSM still completes on the count.
REQ-019 SHALL, on opcode 0 or 5..7 in a header, drop the beat, set err_opcode and stay in IDLE.
REQ-020 SHALL hold cam_tvalid=0 whenever no beat is accepted; gaps in s_axis_tvalid mid-command are permitted and do not advance the counter.
REQ-021 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-022 SHALL, on areset asserted (any time, including mid-command), immediately force state IDLE, cam_state=0, cam_tvalid=0, cam_tdata=0, cam_update_num=0, counters=0, err flags=0, and s_tready=0.
REQ-023 SHALL raise s_tready the first cycle after areset deasserts.
REQ-024 SHALL clear the err flags only by reset.

Structure
REQ-025 SHALL place the opcode enum, OP_CODE_WIDTH, C_DATA_WIDTH and the header field positions in shared package cam_pkg, which is also used by the CAM.
REQ-026 SHALL be a single module with no sub-module; the FSM and beat counter are inline.

Verification
REQ-027 SHALL verify: header op=1, then 16 payload beats, with the model asserting end on beat 16 -> 16 cam_tvalid pulses with cam_state=1, one DRAIN cycle, then IDLE; err_sync=0.
REQ-028 SHALL verify: header op=2 N=3, then 3 beats with a 2-cycle tvalid gap after beat 1 -> 3 forwarded beats, cam_update_num=3, no tvalid during the gap.
REQ-029 SHALL verify: header op=4 with tdata[31:0]=4 -> the same beat appears 1 cycle later with cam_tvalid=1 and cam_state=0; busy stays 0.
REQ-030 SHALL verify: header op=6 -> no cam_tvalid, err_opcode=1, next op=2 N=0 header -> DRAIN then IDLE, no beats forwarded.
REQ-031 SHALL verify: areset asserted after beat 7 of UPDATE_ALL -> all outputs 0 asynchronously; a subsequent UPDATE_ALL completes all 16 beats normally.
REQ-032 SHALL verify: in UPDATE_ALL, the model asserts end on beat 15 -> err_sync=1, and the FSM still forwards 16 beats.
